// File: rtl/fetch_buffer_driver.sv
// Fetch-side driver: pulls words from imem into a small queue and feeds the
// fetch buffer, holding assembled instructions for the pipeline.
module fetch_buffer_driver #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fb_inst,
  output logic        fb_inst_arrived,
  output logic        fb_reset_en,
  output logic [31:0] fb_reset_pc,
  output logic [31:0] fb_reset_pc_val,
  output logic        fb_pc_update,
  output logic        fb_ex_busy,
  input  logic        fb_done,
  input  logic [31:0] fb_result,
  input  logic [31:0] fb_nextpc,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_npc
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_AWAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_q, req_addr_q, rst_pc_q;
  logic          inflight_q, discard_q, redir_q;
  logic [31:0]   qmem_q [QDEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          vld_q;
  logic [31:0]   instr_q, npc_q;

  logic full, empty, consume, pop, push, complete, arrive;

  assign full     = (cnt_q == QFULL);
  assign empty    = (cnt_q == '0);
  assign consume  = vld_q & ~stall;
  assign pop      = (state_q == S_AWAIT) & fb_done & ~redirect_en;
  assign imem_ren = (state_q != S_RST) & (inflight_q | ~full | pop);
  assign imem_addr = inflight_q ? req_addr_q : fetch_q;
  assign complete = imem_ren & ~imem_busy;
  assign push     = complete & ~discard_q & ~redirect_en;

  // The post-reset pulse is gated by nRST so it stays low while held in reset.
  assign fb_reset_en = ((state_q == S_RST) & nRST) | redir_q;
  assign arrive = (state_q == S_IDLE) & ~empty & (~vld_q | consume)
                & ~redir_q & ~redirect_en;

  assign fb_inst         = qmem_q[rd_q];
  assign fb_inst_arrived = arrive;
  assign fb_reset_pc     = rst_pc_q;
  assign fb_reset_pc_val = rst_pc_q;
  assign fb_pc_update    = consume;
  assign fb_ex_busy      = vld_q & stall;
  assign instr_valid     = vld_q;
  assign instr           = instr_q;
  assign instr_npc       = npc_q;

  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_IDLE;
      S_IDLE:  if (arrive) state_d = S_AWAIT;
      S_AWAIT: if (fb_done) state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
    if (redirect_en) state_d = S_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_RST;
      fetch_q    <= RESET_PC & ~32'h3;
      req_addr_q <= RESET_PC & ~32'h3;
      rst_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      redir_q    <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) qmem_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      vld_q      <= 1'b0;
      instr_q    <= '0;
      npc_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= imem_addr;
      inflight_q <= imem_ren & imem_busy;
      redir_q    <= redirect_en;
      if (redirect_en) rst_pc_q <= redirect_pc;
      // A read caught by a redirect completes later; its data is dropped once.
      if (redirect_en & imem_ren & imem_busy) discard_q <= 1'b1;
      else if (complete)                      discard_q <= 1'b0;
      if (redirect_en) begin
        fetch_q <= redirect_pc & ~32'h3;
        rd_q    <= '0;
        wr_q    <= '0;
        cnt_q   <= '0;
        vld_q   <= 1'b0;
      end else begin
        if (push) begin
          qmem_q[wr_q] <= imem_rdata;
          wr_q         <= wr_q + 1'b1;
          fetch_q      <= fetch_q + 32'd4;
        end
        if (pop) rd_q <= rd_q + 1'b1;
        cnt_q <= cnt_d;
        if (pop) begin
          vld_q   <= 1'b1;
          instr_q <= fb_result;
          npc_q   <= fb_nextpc;
        end else if (consume) begin
          vld_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer_driver.sv
// Bench for fetch_buffer_driver: memory, fetch-buffer and pipeline models
// drive the block; a word-stream scoreboard checks what comes out.
module tb_fetch_buffer_driver;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic [31:0] fb_inst;
  logic        fb_inst_arrived;
  logic        fb_reset_en;
  logic [31:0] fb_reset_pc;
  logic [31:0] fb_reset_pc_val;
  logic        fb_pc_update;
  logic        fb_ex_busy;
  logic        fb_done;
  logic [31:0] fb_result;
  logic [31:0] fb_nextpc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_npc;

  fetch_buffer_driver dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_busy(imem_busy), .imem_rdata(imem_rdata),
    .fb_inst(fb_inst), .fb_inst_arrived(fb_inst_arrived),
    .fb_reset_en(fb_reset_en), .fb_reset_pc(fb_reset_pc),
    .fb_reset_pc_val(fb_reset_pc_val), .fb_pc_update(fb_pc_update),
    .fb_ex_busy(fb_ex_busy), .fb_done(fb_done),
    .fb_result(fb_result), .fb_nextpc(fb_nextpc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .instr_npc(instr_npc)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;

  // stimulus knobs
  logic        busy_v = 0, stall_v = 0, redir_v = 0;
  logic [31:0] rpc_v = 0;
  int          lat_lo = 0, lat_hi = 0;

  // reference state
  logic [31:0] exp_w[$];
  logic [31:0] exp_n[$];
  logic [31:0] exp_fa;
  logic        fb_pend;
  logic [31:0] fb_word, fb_npc;
  int          fb_wait;
  logic        rst_exp;
  logic [31:0] rst_pc_exp;
  logic        prev_hold;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h200) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_w.delete();
    exp_n.delete();
    exp_fa     = 32'h200;
    fb_pend    = 0;
    fb_word    = 0;
    fb_npc     = 0;
    fb_wait    = 0;
    rst_exp    = 1;
    rst_pc_exp = 32'h200;
    prev_hold  = 0;
    prev_addr  = 0;
  endtask

  task automatic chk_reset_vals(input string sfx);
    chk({"rv_ren", sfx}, imem_ren, 0);
    chk({"rv_addr", sfx}, imem_addr, 32'h200);
    chk({"rv_inst", sfx}, fb_inst, 0);
    chk({"rv_arr", sfx}, fb_inst_arrived, 0);
    chk({"rv_rsten", sfx}, fb_reset_en, 0);
    chk({"rv_rstpc", sfx}, fb_reset_pc, 32'h200);
    chk({"rv_pcupd", sfx}, fb_pc_update, 0);
    chk({"rv_valid", sfx}, instr_valid, 0);
    chk({"rv_instr", sfx}, instr, 0);
    chk({"rv_npc", sfx}, instr_npc, 0);
  endtask

  // Drive this cycle's inputs and check the generic rules.
  task automatic tick();
    imem_busy   = busy_v;
    stall       = stall_v;
    redirect_en = redir_v;
    redirect_pc = rpc_v;
    fb_done     = fb_pend && fb_wait == 0;
    fb_result   = fb_word;
    fb_nextpc   = fb_npc;
    imem_rdata  = memf(imem_addr);
    #1;
    imem_rdata  = memf(imem_addr);
    if (prev_hold) begin
      chk("ren_hold", imem_ren, 1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    chk("addr_align", imem_addr & 32'h3, 0);
    chk("rst_en", fb_reset_en, rst_exp);
    if (rst_exp) begin
      chk("rst_pc", fb_reset_pc, rst_pc_exp);
      chk("rst_pc_val", fb_reset_pc_val, rst_pc_exp);
    end
    chk("ivalid", instr_valid, exp_w.size() != 0);
    chk("ex_busy", fb_ex_busy, exp_w.size() != 0 && stall_v);
    chk("pc_upd", fb_pc_update, exp_w.size() != 0 && !stall_v);
    if (exp_w.size() != 0) begin
      chk("instr", instr, exp_w[0]);
      chk("npc", instr_npc, exp_n[0]);
    end
    if (fb_inst_arrived) begin
      chk("arr_in_await", fb_pend, 0);
      chk("arr_with_rst", fb_reset_en, 0);
      if (!redir_v) chk("fb_inst", fb_inst, memf(exp_fa));
    end
  endtask

  // Advance the reference models past the coming clock edge.
  task automatic adv();
    if (exp_w.size() != 0 && !stall_v) begin
      void'(exp_w.pop_front());
      void'(exp_n.pop_front());
    end
    if (fb_done && !redir_v) begin
      exp_w.push_back(fb_word);
      exp_n.push_back(fb_npc);
      fb_pend = 0;
    end else if (fb_pend && fb_wait != 0) begin
      fb_wait--;
    end
    if (fb_inst_arrived && !redir_v) begin
      fb_pend = 1;
      fb_word = fb_inst;
      fb_npc  = exp_fa + 32'd4;
      fb_wait = $urandom_range(lat_lo, lat_hi);
    end
    if (fb_inst_arrived) exp_fa = exp_fa + 32'd4;
    if (redir_v) begin
      exp_w.delete();
      exp_n.delete();
      fb_pend    = 0;
      exp_fa     = rpc_v & ~32'h3;
      rst_exp    = 1;
      rst_pc_exp = rpc_v;
    end else begin
      rst_exp = 0;
    end
    prev_hold = imem_ren & imem_busy;
    prev_addr = imem_addr;
    @(negedge CLK);
  endtask

  task automatic cyc();
    tick();
    adv();
  endtask

  initial begin
    int n;
    logic [31:0] a0;
    logic got;
    nRST = 0;
    imem_busy = 0; imem_rdata = 0; fb_done = 0; fb_result = 0;
    fb_nextpc = 0; redirect_en = 0; redirect_pc = 0; stall = 0;
    model_reset();
    @(negedge CLK);
    #1 chk_reset_vals("");
    @(negedge CLK);
    nRST = 1;

    // reset release, zero-wait memory
    tick(); chk("c0_ren", imem_ren, 0); adv();
    tick(); chk("c1_ren", imem_ren, 1);
    chk("c1_addr", imem_addr, 32'h200); adv();
    tick(); chk("c2_arr", fb_inst_arrived, 1);
    chk("c2_inst", fb_inst, 32'h13); adv();
    busy_v = 1;
    tick(); chk("c3_done", fb_done, 1);
    chk("c3_addr", imem_addr, 32'h208); adv();
    tick(); chk("c4_valid", instr_valid, 1);
    chk("c4_instr", instr, 32'h13);
    chk("c4_npc", instr_npc, 32'h204); adv();
    // redirect with fb_done in the same cycle, read to 0x208 in flight
    redir_v = 1; rpc_v = 32'h402;
    tick(); chk("c5_done", fb_done, 1); adv();
    redir_v = 0; busy_v = 0;
    tick(); chk("c6_rsten", fb_reset_en, 1);
    chk("c6_rstpc", fb_reset_pc, 32'h402);
    chk("c6_valid", instr_valid, 0);
    chk("c6_addr", imem_addr, 32'h208);
    chk("c6_arr", fb_inst_arrived, 0); adv();
    tick(); chk("c7_ren", imem_ren, 1);
    chk("c7_addr", imem_addr, 32'h400);
    chk("c7_arr", fb_inst_arrived, 0); adv();
    for (int i = 0; i < 6; i++) cyc();

    // wait states: address held over three busy cycles
    busy_v = 1; n = 0; a0 = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      tick();
      if (imem_ren) begin
        if (n == 0) a0 = imem_addr;
        chk("busy_addr", imem_addr, a0);
        n++;
      end
      adv();
    end
    chk("busy_seen", n, 3);
    busy_v = 0;
    for (int i = 0; i < 6; i++) cyc();

    // stall: queue fills, one instruction held
    stall_v = 1;
    for (int i = 0; i < 4; i++) cyc();
    tick();
    chk("st_ren", imem_ren, 0);
    chk("st_exbusy", fb_ex_busy, 1);
    chk("st_valid", instr_valid, 1);
    chk("st_arr", fb_inst_arrived, 0);
    adv();
    stall_v = 0;
    for (int i = 0; i < 12; i++) cyc();

    // randomized traffic
    lat_lo = 0; lat_hi = 2;
    for (int i = 0; i < 2000; i++) begin
      busy_v  = ($urandom_range(0, 3) == 0);
      stall_v = ($urandom_range(0, 2) == 0);
      redir_v = ($urandom_range(0, 39) == 0);
      rpc_v   = 32'h1000 + ($urandom_range(0, 255) << 1);
      cyc();
    end
    busy_v = 0; stall_v = 0; redir_v = 0;
    for (int i = 0; i < 8; i++) cyc();

    // reset while waiting on the fetch buffer
    lat_lo = 4; lat_hi = 4;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = fb_inst_arrived;
      adv();
    end
    chk("await_reached", got, 1);
    nRST = 0;
    #1 chk_reset_vals("_mid");
    @(negedge CLK);
    #1 chk_reset_vals("_held");
    lat_lo = 0; lat_hi = 0;
    model_reset();
    @(negedge CLK);
    nRST = 1;
    tick(); chk("r0_ren", imem_ren, 0); adv();
    tick(); chk("r1_ren", imem_ren, 1);
    chk("r1_addr", imem_addr, 32'h200); adv();
    tick(); chk("r2_arr", fb_inst_arrived, 1);
    chk("r2_inst", fb_inst, 32'h13); adv();
    for (int i = 0; i < 6; i++) cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_buffer_driver.md
# fetch_buffer_driver

Drives the fetch buffer from the instruction side of the fetch stage. It fetches aligned 32-bit words from instruction memory over the generic bus into a 2-entry word queue, and hands words to the fetch buffer with an `inst_arrived`/`done` handshake. It forwards assembled instructions to the pipeline through a held output register and converts pipeline redirects into fetch-buffer resets with queue flush.

## Interface
- `RESET_PC`, 32'h0000_0200, PC loaded after reset.
- `QDEPTH`, 2, word queue entries (power of two, ≥2).

Ports:
- `CLK`  in  1  clock; the block has one clock.
- `nRST`  in  1  reset, asynchronous, active-low.
- `imem_ren`  out  1  read request, held until `imem_busy`=0.
- `imem_addr`  out  32  word-aligned read address, bits [1:0]=0.
- `imem_busy`  in  1  bus not done; the read completes in the cycle `imem_ren`=1 and `imem_busy`=0.
- `imem_rdata`  in  32  read data, valid when the read completes.
- `fb_inst`  out  32  word presented to the fetch buffer.
- `fb_inst_arrived`  out  1  one-cycle pulse: `fb_inst` valid.
- `fb_reset_en`  out  1  one-cycle pulse: reset the fetch buffer.
- `fb_reset_pc`, `fb_reset_pc_val`  out  32  new PC, both equal, valid with `fb_reset_en`.
- `fb_pc_update`  out  1  pulse: the pipeline consumed the current instruction.
- `fb_ex_busy`  out  1  equals `instr_valid & stall`.
- `fb_done`  in  1  fetch buffer consumed the word and produced `fb_result`.
- `fb_result`  in  32  assembled instruction (32-bit or expanded RVC).
- `fb_nextpc`  in  32  PC following `fb_result`.
- `redirect_en`  in  1  branch/jump/exception redirect pulse.
- `redirect_pc`  in  32  redirect target (halfword-aligned).
- `stall`  in  1  pipeline cannot accept the instruction this cycle.
- `instr_valid`  out  1  output register holds an instruction.
- `instr`, `instr_npc`  out  32  instruction and its next PC.

## Operation
- Fetch side: register `fetch_addr`.
  - A read issues when the queue is not full, or when it will not be full after a pop in the same cycle.
  - On completion: push `imem_rdata` and set `fetch_addr += 4`. Wrap at 2^32 is allowed.
  - `imem_addr` = `fetch_addr`. Only one read is outstanding at a time.
- Delivery FSM, states `RST`, `IDLE`, `AWAIT`:
  - `RST`: lasts one cycle after `nRST` deasserts. Pulses `fb_reset_en` with `RESET_PC`, then goes to `IDLE`.
  - `IDLE`: when the queue is non-empty and the output register is empty or being consumed this cycle:
    - `fb_inst` = head.
    - Pulse `fb_inst_arrived`.
    - Go to `AWAIT`.
  - `AWAIT`: on `fb_done`:
    - Pop the head.
    - Load `instr`=`fb_result`, `instr_npc`=`fb_nextpc`, `instr_valid`=1.
    - Go to `IDLE`.
- Output register: consumed when `instr_valid & ~stall`. That cycle `fb_pc_update`=1, and `instr_valid` clears unless reloaded in the same cycle.
- Redirect has priority over every same-cycle event:
  - Flush the queue and clear `instr_valid`.
  - `fb_done`/`fb_result` in that cycle are discarded.
  - Next cycle: pulse `fb_reset_en` with `redirect_pc`, FSM goes to `IDLE`, `fetch_addr` = `redirect_pc & ~3`.
  - If a read is outstanding: keep `imem_ren`/`imem_addr` until completion, discard its data (no push), then fetch from the new address.
  - A second redirect before the discarded read completes overrides the target. The discard is still applied exactly once.
- Full queue: no read issues. Empty queue: no `fb_inst_arrived`.

## Timing
- Reset values: `imem_ren`=0, `imem_addr`=`RESET_PC & ~3`, `fb_inst`=0, `fb_inst_arrived`=0, `fb_reset_en`=0, `fb_reset_pc`=`RESET_PC`, `fb_pc_update`=0, `instr_valid`=0, `instr`=0, `instr_npc`=0, queue empty, FSM=`RST`.
- First `imem_ren`: the cycle after `RST`.
- Read completes in cycle t → `fb_inst_arrived` at t+1 at the earliest.
- `fb_done` at t → `instr_valid` at t+1.
- `redirect_en` at t → `fb_reset_en` at t+1, new `imem_addr` at t+1 if no read is outstanding.
- `fb_inst_arrived` never pulses while `fb_reset_en`=1 or in `AWAIT`.
- Asserting `nRST` mid-operation immediately restores all reset values. It abandons the bus request; the bus is reset by the same `nRST`.

## Test plan
- Reset release, zero-wait memory returning 0x0000_0013 at 0x200 → `fb_reset_en`/`fb_reset_pc`=0x200 for one cycle; `imem_addr`=0x200; `fb_inst_arrived` with `fb_inst`=0x13; `fb_done` with `fb_result`=0x13, `fb_nextpc`=0x204 → `instr_valid`, `instr`=0x13, `instr_npc`=0x204.
- `imem_busy`=1 for 3 cycles → `imem_ren`/`imem_addr` stable; data pushed only on the completion cycle.
- `stall`=1 for 5 cycles with a stream of words → queue fills to 2, `imem_ren`=0, `fb_ex_busy`=1, a single instruction is held; on release, `fb_pc_update` pulses once per consumed instruction, none lost or duplicated.
- `redirect_en` with `redirect_pc`=0x402 while a read at 0x208 is outstanding → 0x208 data dropped; `fb_reset_pc`=0x402; next `imem_addr`=0x400.
- `redirect_en` and `fb_done` in the same cycle → no `instr_valid`; queue empty next cycle.
- `nRST` asserted mid-`AWAIT` → all outputs at reset values; restart fetch at 0x200.
